mru_frame_serializer: RTL and testbench
=======================================

// Module: mru_frame_serializer
// PURPOSE
// Downstream consumer of the 4-entry MRU list stage. Watches its out_*/out_valid_* outputs every
// clock and, whenever the list changes, serializes a snapshot of the valid entries as one frame
// on a valid/ready stream. Changes that arrive during a frame are coalesced into one follow-up frame.
// PARAMETERS
// DATA_W  8  width of each list entry and of m_data
// CNT_W   8  width of the saturating coalesce counter
// PORTS
// clk_in        in   1       clock, all logic on rising edge
// reset_n_in    in   1       asynchronous reset, active low
// in_0..in_3    in   DATA_W  list entries from the MRU stage (index 0 = most recent)
// in_valid_0..3 in   1       per-entry valid from the MRU stage
// m_data        out  DATA_W  beat payload = snapshot entry
// m_idx         out  2       list index of the beat
// m_last        out  1       final beat of the frame
// m_valid       out  1       beat valid
// m_ready       in   1       sink ready; beat transfers when m_valid && m_ready
// busy          out  1       high while a frame is in progress (state SEND)
// coalesce_cnt  out  CNT_W   count of list changes merged into a pending frame, saturating
// BEHAVIOUR
// - Reset (async, reset_n_in=0): m_data=0, m_idx=0, m_last=0, m_valid=0, busy=0, coalesce_cnt=0,
//   state=IDLE, pending=0, shadow list all-invalid, snapshot cleared. Frame in flight is abandoned.
// - Shadow: registered copy of in_*/in_valid_*, updated every clock.
// - change = any in_valid_i != shadow_valid_i, OR any i with in_valid_i=1 and in_i != shadow_i.
//   Data of invalid entries is ignored.
// - All outputs are registered. m_data/m_idx/m_last stay stable while m_valid=1 && m_ready=0.
// - Beats go out in ascending index order, skipping invalid entries. m_last is set on the
//   highest valid index. The MRU stage fills entries contiguously, but the serializer does
//   not depend on that.
// - FSM IDLE:
//   - change && any in_valid_i: capture the live inputs into the snapshot, go to SEND, and
//     load the first beat. m_valid rises on that same edge, so the first beat is visible
//     1 cycle after the change is sampled.
//   - change with all entries invalid: stay in IDLE, emit nothing.
// - FSM SEND, on a handshake that is not the last beat: load the next valid index.
//   Back-to-back beats, one per clock, while m_ready=1.
// - FSM SEND, on the handshake of the last beat:
//   - if pending || change: recapture the live inputs, clear pending, and present the next
//     frame's first beat on the following cycle (no idle gap).
//   - if that recapture has all entries invalid: go to IDLE.
//   - otherwise: go to IDLE with m_valid=0.
// - While in SEND, change sets pending.
// - coalesce_cnt += 1 on every cycle with change && pending=1 (this includes the final-handshake
//   cycle). It saturates at 2^CNT_W-1 and is cleared only by reset.
// - busy = (state == SEND).
// TESTING
// 1. After reset: in_valid_0=1, in_0=0x11, others invalid; m_ready=1 -> one beat next cycle:
//    m_data=0x11, m_idx=0, m_last=1; then m_valid=0 and busy=0.
// 2. Full list {0x44,0x33,0x22,0x11}, all valid; m_ready=1 -> 4 consecutive beats, idx 0..3,
//    data 0x44,0x33,0x22,0x11, m_last only on idx 3.
// 3. Backpressure: m_ready=0 for 5 cycles at beat idx1 -> m_valid stays 1, m_data=0x33 and
//    m_idx=1 stay stable; the frame completes after m_ready returns to 1.
// 4. Coalescing: m_ready=0 mid-frame, inputs change 3 times -> after m_last accepts, exactly
//    one follow-up frame carrying the final values, and coalesce_cnt=2.
// 5. Inputs held for 20 cycles, and separately invalid-entry data toggled -> no frame; with
//    CNT_W=2, 6 merged changes -> coalesce_cnt sticks at 3.
// 6. reset_n_in pulsed low between clock edges during beat idx2 -> m_valid=0 immediately.
//    After release, the still-valid upstream list counts as a change, so a full new frame
//    starts from idx 0.

Source files
------------

// File: rtl/mru_frame_serializer.sv
// Serializes a snapshot of the MRU list as a frame of beats whenever the list changes.
// List changes that arrive during a frame are merged into one follow-up frame.
module mru_frame_serializer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_idx,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  coalesce_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic                     pending_q, pending_d;
  logic [3:0][DATA_W-1:0]   shadow_q;
  logic [3:0]               shadowValid_q;
  logic [3:0][DATA_W-1:0]   snap_q, snap_d;
  logic [3:0]               snapValid_q, snapValid_d;
  logic [DATA_W-1:0]        mData_q, mData_d;
  logic [1:0]               mIdx_q, mIdx_d;
  logic                     mLast_q, mLast_d;
  logic                     mValid_q, mValid_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [3:0][DATA_W-1:0]   live;
  logic [3:0]               liveValid;
  logic                     change;
  logic [1:0]               liveFirst, liveHigh, snapNext, snapHigh;

  assign live      = {in_3, in_2, in_1, in_0};
  assign liveValid = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  // Lowest valid index at or above start.
  function automatic logic [1:0] firstFrom(input logic [3:0] v, input int start);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i >= start && v[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  assign liveFirst = firstFrom(liveValid, 0);
  assign liveHigh  = highest(liveValid);
  assign snapNext  = firstFrom(snapValid_q, int'(mIdx_q) + 1);
  assign snapHigh  = highest(snapValid_q);

  // Data of an invalid entry never counts as a change.
  always_comb begin
    change = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (liveValid[i] != shadowValid_q[i]) change = 1'b1;
      else if (liveValid[i] && (live[i] != shadow_q[i])) change = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    snap_d      = snap_q;
    snapValid_d = snapValid_q;
    mData_d     = mData_q;
    mIdx_d      = mIdx_q;
    mLast_d     = mLast_q;
    mValid_d    = mValid_q;
    cnt_d       = cnt_q;

    if (change && pending_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (change && (|liveValid)) begin
          snap_d      = live;
          snapValid_d = liveValid;
          state_d     = SEND;
          mValid_d    = 1'b1;
          mIdx_d      = liveFirst;
          mData_d     = live[liveFirst];
          mLast_d     = (liveFirst == liveHigh);
        end
      end
      SEND: begin
        if (change) pending_d = 1'b1;
        if (mValid_q && m_ready) begin
          if (!mLast_q) begin
            mIdx_d  = snapNext;
            mData_d = snap_q[snapNext];
            mLast_d = (snapNext == snapHigh);
          end else if (pending_q || change) begin
            // Follow-up frame starts straight away from the current live list.
            snap_d      = live;
            snapValid_d = liveValid;
            pending_d   = 1'b0;
            if (|liveValid) begin
              mIdx_d  = liveFirst;
              mData_d = live[liveFirst];
              mLast_d = (liveFirst == liveHigh);
            end else begin
              state_d  = IDLE;
              mValid_d = 1'b0;
              mLast_d  = 1'b0;
            end
          end else begin
            state_d  = IDLE;
            mValid_d = 1'b0;
            mLast_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      shadow_q      <= '0;
      shadowValid_q <= '0;
      snap_q        <= '0;
      snapValid_q   <= '0;
      mData_q       <= '0;
      mIdx_q        <= '0;
      mLast_q       <= 1'b0;
      mValid_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      shadow_q      <= live;
      shadowValid_q <= liveValid;
      snap_q        <= snap_d;
      snapValid_q   <= snapValid_d;
      mData_q       <= mData_d;
      mIdx_q        <= mIdx_d;
      mLast_q       <= mLast_d;
      mValid_q      <= mValid_d;
      cnt_q         <= cnt_d;
    end
  end

  assign m_data       = mData_q;
  assign m_idx        = mIdx_q;
  assign m_last       = mLast_q;
  assign m_valid      = mValid_q;
  assign busy         = (state_q == SEND);
  assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_mru_frame_serializer.sv
// Scoreboard bench for mru_frame_serializer: expected beats are queued as lists are driven
// and compared at the falling edge whenever the serializer presents a beat.
module tb_mru_frame_serializer;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic       clk_in = 1'b0;
  logic       reset_n_in = 1'b0;
  logic [7:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic       in_valid_0 = 1'b0, in_valid_1 = 1'b0, in_valid_2 = 1'b0, in_valid_3 = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic [1:0] m_idx;
  logic       m_last, m_valid, busy;
  logic [1:0] coalesce_cnt;

  beat_t sb[$];
  int    totalChecks = 0;
  int    badChecks = 0;

  mru_frame_serializer #(.DATA_W(8), .CNT_W(2)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_valid_2(in_valid_2), .in_valid_3(in_valid_3),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .coalesce_cnt(coalesce_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d0, d1, d2, d3, input logic [3:0] v);
    in_0 = d0; in_1 = d1; in_2 = d2; in_3 = d3;
    {in_valid_3, in_valid_2, in_valid_1, in_valid_0} = v;
  endtask

  // Expected frame: valid entries in ascending order, last flag on the highest one.
  task automatic pushFrame(input logic [7:0] d0, d1, d2, d3, input logic [3:0] v);
    logic [7:0] d [4];
    int hi;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    hi = -1;
    for (int i = 0; i < 4; i++) if (v[i]) hi = i;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) sb.push_back('{data: d[i], idx: 2'(i), last: (i == hi)});
    end
  endtask

  // Every cycle a beat is on the bus it must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (reset_n_in && m_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedBeat", 32'd1, 32'd0);
      end else begin
        checkOutput("beatData", 32'(m_data), 32'(sb[0].data));
        checkOutput("beatIdx", 32'(m_idx), 32'(sb[0].idx));
        checkOutput("beatLast", 32'(m_last), 32'(sb[0].last));
        if (m_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic resetDut();
    applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    m_ready = 1'b1;
    reset_n_in = 1'b0;
    waitCycle();
    waitCycle();
    checkOutput("rstValid", 32'(m_valid), 32'd0);
    checkOutput("rstData", 32'(m_data), 32'd0);
    checkOutput("rstIdx", 32'(m_idx), 32'd0);
    checkOutput("rstLast", 32'(m_last), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCnt", 32'(coalesce_cnt), 32'd0);
    sb.delete();
    reset_n_in = 1'b1;
    waitCycle();
  endtask

  task automatic waitForIdx(input logic [1:0] idx, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (m_valid && m_idx == idx) found = 1'b1;
      else waitCycle();
    end
    checkOutput("waitIdxTimeout", 32'(found), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      waitCycle();
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    waitCycle();
    waitCycle();
    checkOutput("idleValid", 32'(m_valid), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Single-entry frame
    resetDut();
    applyStimulus(8'h11, 8'h00, 8'h00, 8'h00, 4'b0001);
    pushFrame(8'h11, 8'h00, 8'h00, 8'h00, 4'b0001);
    waitDrain(20);

    // Full list, back-to-back beats
    applyStimulus(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    pushFrame(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    waitDrain(20);

    // All-invalid change is silent, then backpressure on idx1
    applyStimulus(8'h44, 8'h33, 8'h22, 8'h11, 4'b0000);
    waitCycle();
    waitCycle();
    checkOutput("emptyNoBusy", 32'(busy), 32'd0);
    applyStimulus(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    pushFrame(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    waitForIdx(2'd1, 20);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      checkOutput("bpValid", 32'(m_valid), 32'd1);
      checkOutput("bpIdx", 32'(m_idx), 32'd1);
      checkOutput("bpData", 32'(m_data), 32'h33);
    end
    m_ready = 1'b1;
    waitDrain(20);

    // Three changes during a stalled frame merge into one follow-up frame
    resetDut();
    applyStimulus(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    pushFrame(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111);
    waitForIdx(2'd1, 20);
    m_ready = 1'b0;
    applyStimulus(8'h55, 8'h33, 8'h22, 8'h11, 4'b1111);
    waitCycle();
    applyStimulus(8'h55, 8'h66, 8'h22, 8'h11, 4'b1111);
    waitCycle();
    applyStimulus(8'h55, 8'h66, 8'h77, 8'h11, 4'b1111);
    waitCycle();
    pushFrame(8'h55, 8'h66, 8'h77, 8'h11, 4'b1111);
    checkOutput("coalesceBusy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    waitDrain(30);
    checkOutput("coalesceCnt", 32'(coalesce_cnt), 32'd2);

    // Held inputs and invalid-entry data produce nothing
    applyStimulus(8'hA1, 8'hA2, 8'h00, 8'h00, 4'b0011);
    pushFrame(8'hA1, 8'hA2, 8'h00, 8'h00, 4'b0011);
    waitDrain(20);
    for (int i = 0; i < 20; i++) waitCycle();
    checkOutput("holdBusy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'hA1, 8'hA2, 8'(i * 17 + 3), 8'(i * 29 + 5), 4'b0011);
      waitCycle();
    end
    waitCycle();
    checkOutput("invDataBusy", 32'(busy), 32'd0);
    checkOutput("invDataValid", 32'(m_valid), 32'd0);

    // Counter saturates at 3 with a 2-bit width
    resetDut();
    m_ready = 1'b0;
    applyStimulus(8'h10, 8'h00, 8'h00, 8'h00, 4'b0001);
    pushFrame(8'h10, 8'h00, 8'h00, 8'h00, 4'b0001);
    waitCycle();
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(8'(8'h10 + k * 8'h10), 8'h00, 8'h00, 8'h00, 4'b0001);
      waitCycle();
    end
    checkOutput("satCnt", 32'(coalesce_cnt), 32'd3);
    pushFrame(8'h80, 8'h00, 8'h00, 8'h00, 4'b0001);
    m_ready = 1'b1;
    waitDrain(20);
    checkOutput("satCntHold", 32'(coalesce_cnt), 32'd3);

    // Async reset mid-frame abandons it; the still-valid list restarts a full frame
    resetDut();
    applyStimulus(8'h91, 8'h92, 8'h93, 8'h94, 4'b1111);
    pushFrame(8'h91, 8'h92, 8'h93, 8'h94, 4'b1111);
    waitForIdx(2'd2, 20);
    m_ready = 1'b0;
    #2;
    reset_n_in = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(m_valid), 32'd0);
    checkOutput("asyncRstBusy", 32'(busy), 32'd0);
    sb.delete();
    #2;
    pushFrame(8'h91, 8'h92, 8'h93, 8'h94, 4'b1111);
    m_ready = 1'b1;
    reset_n_in = 1'b1;
    waitCycle();
    checkOutput("restartValid", 32'(m_valid), 32'd1);
    checkOutput("restartIdx", 32'(m_idx), 32'd0);
    waitDrain(20);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
